// File: rtl/bsg_gateway_tag_pkg.sv
// Purpose: shared types and sizing helpers for the tag-link receiver.
//   tag_state_e   - deframer FSM states
//   tag_hdr_s     - packet header layout {id, dnr, len} at the default field widths
//   TAG_HDR_BITS  - start + id + dnr + len bit count at the default field widths
//   tag_cnt_width - width of the shared field bit counter
package bsg_gateway_tag_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ID,
        ST_DNR,
        ST_LEN,
        ST_DATA,
        ST_STOP
    } tag_state_e;

    localparam int unsigned TAG_ID_W  = 4;
    localparam int unsigned TAG_LEN_W = 6;

    typedef struct packed {
        logic [TAG_ID_W-1:0]  id;
        logic                 dnr;
        logic [TAG_LEN_W-1:0] len;
    } tag_hdr_s;

    localparam int unsigned TAG_HDR_BITS = 2 + TAG_ID_W + TAG_LEN_W;

    // Counter must cover the widest of the id field, the len field and the longest data field.
    function automatic int unsigned tag_cnt_width(input int unsigned id_w, input int unsigned len_w);
        int unsigned m;
        m = id_w;
        if (len_w > m) m = len_w;
        if ((32'd1 << len_w) > m) m = 32'd1 << len_w;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/bsg_gateway_tag_rx.sv
// Purpose: deframes LSB-first tag packets {start, id, dnr, len, payload, stop}
//          addressed to node_id_p and presents the payload as a held parallel word.
// Ports:
//   clk_i           - link clock, TDI/TMS sampled on rising edge
//   reset_i         - asynchronous active-high reset
//   tag_tdi_i       - serial data
//   tag_tms_i       - abort; forces the receiver back to IDLE
//   payload_o       - last accepted payload (held)
//   payload_valid_o - one-cycle pulse when a data packet updates payload_o
//   client_reset_o  - one-cycle pulse when a client-reset packet is accepted
//   err_o           - one-cycle pulse on a framing error for this node
//   busy_o          - high while a packet is being received
module bsg_gateway_tag_rx
    import bsg_gateway_tag_pkg::*;
#(
    parameter int unsigned node_id_p       = 0,
    parameter int unsigned id_width_p      = 4,
    parameter int unsigned len_width_p     = 6,
    parameter int unsigned payload_width_p = 36,
    parameter logic [payload_width_p-1:0] reset_value_p = '0
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic                       tag_tdi_i,
    input  logic                       tag_tms_i,
    output logic [payload_width_p-1:0] payload_o,
    output logic                       payload_valid_o,
    output logic                       client_reset_o,
    output logic                       err_o,
    output logic                       busy_o
);

    localparam int unsigned CNT_W = tag_cnt_width(id_width_p, len_width_p);

    tag_state_e                 r_state;
    logic [CNT_W-1:0]           r_cnt;
    logic [id_width_p-1:0]      r_id;
    logic                       r_dnr;
    logic [len_width_p-1:0]     r_len;
    logic [payload_width_p-1:0] r_shift;
    logic [payload_width_p-1:0] r_payload;
    logic                       r_valid;
    logic                       r_crst;
    logic                       r_err;
    logic                       r_busy;

    logic [id_width_p-1:0]      w_id_next;
    logic [len_width_p-1:0]     w_len_next;
    logic [CNT_W-1:0]           w_data_idx;
    logic                       w_idx_ok;
    logic                       w_len_bad;
    logic                       w_id_hit;

    // Fields arrive LSB-first, so shift in from the top.
    assign w_id_next  = {tag_tdi_i, r_id[id_width_p-1:1]};
    assign w_len_next = {tag_tdi_i, r_len[len_width_p-1:1]};

    // Counter runs down from len-1, so the current payload bit index is len-1-cnt.
    assign w_data_idx = CNT_W'(r_len) - CNT_W'(1) - r_cnt;
    assign w_idx_ok   = 32'(w_data_idx) < 32'(payload_width_p);
    assign w_len_bad  = 32'(r_len) > 32'(payload_width_p);
    assign w_id_hit   = (r_id == id_width_p'(node_id_p));

    // Deframer FSM with registered outputs; tms overrides every transition.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_id      <= '0;
            r_dnr     <= 1'b0;
            r_len     <= '0;
            r_shift   <= '0;
            r_payload <= reset_value_p;
            r_valid   <= 1'b0;
            r_crst    <= 1'b0;
            r_err     <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            r_crst  <= 1'b0;
            r_err   <= 1'b0;
            if (tag_tms_i) begin
                r_state <= ST_IDLE;
                r_busy  <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (tag_tdi_i) begin
                            r_state <= ST_ID;
                            r_cnt   <= CNT_W'(id_width_p - 1);
                            r_shift <= '0;
                            r_busy  <= 1'b1;
                        end
                    end
                    ST_ID: begin
                        r_id <= w_id_next;
                        if (r_cnt == '0) r_state <= ST_DNR;
                        else             r_cnt   <= r_cnt - CNT_W'(1);
                    end
                    ST_DNR: begin
                        r_dnr   <= tag_tdi_i;
                        r_state <= ST_LEN;
                        r_cnt   <= CNT_W'(len_width_p - 1);
                    end
                    ST_LEN: begin
                        r_len <= w_len_next;
                        if (r_cnt == '0) begin
                            if (w_len_next == '0) begin
                                r_state <= ST_STOP;
                            end else begin
                                r_state <= ST_DATA;
                                r_cnt   <= CNT_W'(w_len_next) - CNT_W'(1);
                            end
                        end else begin
                            r_cnt <= r_cnt - CNT_W'(1);
                        end
                    end
                    ST_DATA: begin
                        // Bits beyond the payload width are consumed but dropped.
                        if (w_idx_ok) r_shift[w_data_idx] <= tag_tdi_i;
                        if (r_cnt == '0) r_state <= ST_STOP;
                        else             r_cnt   <= r_cnt - CNT_W'(1);
                    end
                    ST_STOP: begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                        if (w_id_hit) begin
                            if (tag_tdi_i || w_len_bad) begin
                                r_err <= 1'b1;
                            end else if (r_dnr) begin
                                r_payload <= r_shift;
                                r_valid   <= 1'b1;
                            end else begin
                                r_payload <= reset_value_p;
                                r_crst    <= 1'b1;
                            end
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign payload_o       = r_payload;
    assign payload_valid_o = r_valid;
    assign client_reset_o  = r_crst;
    assign err_o           = r_err;
    assign busy_o          = r_busy;

endmodule

// File: tb/tb_bsg_gateway_tag_rx.sv
// Purpose: self-checking bench for bsg_gateway_tag_rx (node 3, 4-bit id, 6-bit len, 36-bit payload).
module tb_bsg_gateway_tag_rx;

    localparam int unsigned PW = 36;
    localparam logic [PW-1:0] RST_VAL = 36'hC_0000_0005;

    logic          clk;
    logic          rst;
    logic          tdi;
    logic          tms;
    logic [PW-1:0] payload;
    logic          valid;
    logic          crst;
    logic          err;
    logic          busy;

    int checks;
    int errors;

    bsg_gateway_tag_rx #(
        .node_id_p      (3),
        .id_width_p     (4),
        .len_width_p    (6),
        .payload_width_p(PW),
        .reset_value_p  (RST_VAL)
    ) dut (
        .clk_i          (clk),
        .reset_i        (rst),
        .tag_tdi_i      (tdi),
        .tag_tms_i      (tms),
        .payload_o      (payload),
        .payload_valid_o(valid),
        .client_reset_o (crst),
        .err_o          (err),
        .busy_o         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Packet-level model: collects the bits following a start bit and judges the
    // packet once its length field says it is complete.
    logic [PW-1:0] m_payload;
    logic          m_valid, m_crst, m_err, m_busy;
    bit            q[$];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_payload = RST_VAL;
            m_valid = 1'b0; m_crst = 1'b0; m_err = 1'b0; m_busy = 1'b0;
            q.delete();
        end else begin
            m_valid = 1'b0; m_crst = 1'b0; m_err = 1'b0;
            if (tms) begin
                m_busy = 1'b0;
                q.delete();
            end else if (!m_busy) begin
                if (tdi) m_busy = 1'b1;
                q.delete();
            end else begin
                int len;
                q.push_back(tdi);
                len = 0;
                if (q.size() >= 11) begin
                    for (int k = 0; k < 6; k++) len += int'(q[5+k]) << k;
                    if (q.size() == 12 + len) begin
                        int id;
                        logic [PW-1:0] pl;
                        id = 0;
                        for (int k = 0; k < 4; k++) id += int'(q[k]) << k;
                        pl = '0;
                        for (int k = 0; k < len && k < int'(PW); k++) pl[k] = q[11+k];
                        if (id == 3) begin
                            if (q[11+len] || len > int'(PW)) m_err = 1'b1;
                            else if (q[4]) begin m_payload = pl; m_valid = 1'b1; end
                            else begin m_payload = RST_VAL; m_crst = 1'b1; end
                        end
                        m_busy = 1'b0;
                        q.delete();
                    end
                end
            end
        end
    end

    task automatic lit(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of every output against the model.
    task automatic cmp_model();
        lit("model_payload", 64'(payload), 64'(m_payload));
        lit("model_valid",   64'(valid),   64'(m_valid));
        lit("model_crst",    64'(crst),    64'(m_crst));
        lit("model_err",     64'(err),     64'(m_err));
        lit("model_busy",    64'(busy),    64'(m_busy));
        lit("one_hot_pulse", 64'(int'(valid) + int'(crst) + int'(err) <= 1), 64'(1));
    endtask

    // Drive one bit, let the DUT sample it, compare at the next falling edge.
    task automatic drive_bit(input bit b, input bit t);
        tdi = b;
        tms = t;
        @(negedge clk);
        cmp_model();
        #1;
    endtask

    // abort_at: bit index replaced by a tms pulse; cut_at: stop driving before that index.
    task automatic send_pkt(input int id, input bit dnr, input int len, input logic [63:0] data,
                            input bit stop, input int abort_at, input int cut_at, input bit chk_busy);
        bit bits[$];
        bits.push_back(1'b1);
        for (int i = 0; i < 4; i++) bits.push_back(((id >> i) & 1) != 0);
        bits.push_back(dnr);
        for (int i = 0; i < 6; i++) bits.push_back(((len >> i) & 1) != 0);
        for (int i = 0; i < len; i++) bits.push_back(data[i]);
        bits.push_back(stop);
        for (int i = 0; i < bits.size(); i++) begin
            if (i == cut_at) return;
            if (i == abort_at) begin
                drive_bit(bits[i], 1'b1);
                return;
            end
            drive_bit(bits[i], 1'b0);
            if (chk_busy) lit("busy_window", 64'(busy), 64'(i < bits.size() - 1));
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        tdi = 1'b0;
        tms = 1'b0;
        repeat (2) @(negedge clk);
        lit("rst_payload", 64'(payload), 64'(RST_VAL));
        lit("rst_pulses",  64'({valid, crst, err}), 64'(0));
        lit("rst_busy",    64'(busy), 64'(0));
        #1 rst = 1'b0;
        drive_bit(0, 0);
        drive_bit(0, 0);

        // Data packet for this node; pulse lands 21 cycles after the start bit.
        send_pkt(3, 1, 8, 64'hA5, 0, -1, -1, 1);
        lit("pkt1_valid",   64'(valid),   64'(1));
        lit("pkt1_payload", 64'(payload), 64'h0A5);
        drive_bit(0, 0);
        lit("pkt1_valid_once", 64'(valid), 64'(0));

        // Foreign node: busy but silent.
        send_pkt(5, 1, 8, 64'hA5, 0, -1, -1, 1);
        lit("foreign_pulses",  64'({valid, crst, err}), 64'(0));
        lit("foreign_payload", 64'(payload), 64'h0A5);
        drive_bit(0, 0);

        // Client reset, len=0: pulse 13 cycles after start.
        send_pkt(3, 0, 0, 64'h0, 0, -1, -1, 0);
        lit("crst_pulse",   64'(crst),    64'(1));
        lit("crst_valid",   64'(valid),   64'(0));
        lit("crst_payload", 64'(payload), 64'(RST_VAL));
        drive_bit(0, 0);

        // Full-width boundary.
        send_pkt(3, 1, 36, 64'h8_0000_0001, 0, -1, -1, 0);
        lit("len36_payload", 64'(payload), 64'h8_0000_0001);
        drive_bit(0, 0);

        send_pkt(3, 1, 8, 64'h3C, 0, -1, -1, 0);
        drive_bit(0, 0);
        // Over-long packet, then a back-to-back packet with no idle gap.
        send_pkt(3, 1, 40, 64'hFF_FFFF_FFFF, 0, -1, -1, 0);
        lit("long_err",     64'(err),     64'(1));
        lit("long_payload", 64'(payload), 64'h3C);
        send_pkt(3, 1, 16, 64'h1234, 0, -1, -1, 0);
        lit("b2b_valid",   64'(valid),   64'(1));
        lit("b2b_payload", 64'(payload), 64'h1234);
        drive_bit(0, 0);

        // tms abort inside DATA, then a normal packet.
        send_pkt(3, 1, 8, 64'h77, 0, 14, -1, 0);
        lit("abort_busy",   64'(busy), 64'(0));
        lit("abort_pulses", 64'({valid, crst, err}), 64'(0));
        drive_bit(0, 0);
        send_pkt(3, 1, 8, 64'hF0, 0, -1, -1, 0);
        lit("after_abort_payload", 64'(payload), 64'hF0);
        drive_bit(0, 0);

        // Bad stop bit; tdi is returned low before the next sample.
        send_pkt(3, 1, 8, 64'h11, 1, -1, -1, 0);
        lit("stop_err",     64'(err),     64'(1));
        lit("stop_valid",   64'(valid),   64'(0));
        lit("stop_payload", 64'(payload), 64'hF0);
        drive_bit(0, 0);

        // Async reset while in LEN: outputs clear without a clock edge.
        send_pkt(3, 1, 8, 64'h5A, 0, -1, 9, 0);
        lit("midlen_busy", 64'(busy), 64'(1));
        tdi = 1'b0;
        rst = 1'b1;
        #1;
        lit("async_payload", 64'(payload), 64'(RST_VAL));
        lit("async_busy",    64'(busy), 64'(0));
        lit("async_pulses",  64'({valid, crst, err}), 64'(0));
        drive_bit(0, 0);
        rst = 1'b0;
        drive_bit(0, 0);
        send_pkt(3, 1, 8, 64'h5A, 0, -1, -1, 0);
        lit("post_reset_payload", 64'(payload), 64'h5A);
        drive_bit(0, 0);
        drive_bit(0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
